// File: rtl/uart_reg_responder_if.sv
// Byte-level handshake between the UART core and the register responder.
// The slave modport is the responder side, the master modport the UART side.
interface uart_reg_responder_if;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;

    modport slave (
        input  rx_valid, rx_byte, rx_err, tx_busy,
        output tx_start, tx_byte
    );

    modport master (
        output rx_valid, rx_byte, rx_err, tx_busy,
        input  tx_start, tx_byte
    );
endinterface

// File: rtl/uart_reg_responder.sv
// Parses host frames (A5 CMD ADDR [DATA] CHK) from UART bytes, executes register
// writes/reads on a flat register file and streams the response back to the UART.
module uart_reg_responder #(
    parameter int NREGS   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 500_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_reg_responder_if.slave  uart,
    output logic [NREGS*8-1:0]   reg_out,
    output logic                 wr_strobe,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_SYNC, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_TX, S_WAIT
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  CMD_WR    = 8'h01;
    localparam logic [7:0]  CMD_RD    = 8'h02;
    localparam logic [7:0]  RESP_OK   = 8'h5A;
    localparam logic [7:0]  RESP_ERR  = 8'hEE;
    localparam logic [19:0] TMO_LAST  = 20'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        chk_q, chk_d;
    logic [19:0]       tmo_q, tmo_d;
    logic [2:0][7:0]   resp_q, resp_d;
    logic [1:0]        len_q, len_d;
    logic [1:0]        idx_q, idx_d;
    logic              seen_busy_q, seen_busy_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic [ADDR_W-1:0] addr_idx;
    logic              addr_ok;
    logic              is_wr;
    logic              is_rd;
    logic              frame_ok;
    logic              reg_we;
    logic [7:0]        rd_data;

    // Frame validation, evaluated while in S_EXEC; the running XOR includes CHK, so zero means match.
    always_comb begin
        addr_idx = addr_q[ADDR_W-1:0];
        addr_ok  = ({1'b0, addr_q} < 9'(NREGS));
        is_wr    = (cmd_q == CMD_WR);
        is_rd    = (cmd_q == CMD_RD);
        frame_ok = (chk_q == 8'h00) && (is_wr || is_rd) && addr_ok;
        reg_we   = (state_q == S_EXEC) && frame_ok && is_wr;
        rd_data  = reg_out[{addr_idx, 3'b000} +: 8];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [7:0] reg_q, reg_d;

            always_comb begin
                reg_d = reg_q;
                if (reg_we && (addr_idx == ADDR_W'(gi))) begin
                    reg_d = data_q;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    reg_q <= 8'h00;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign reg_out[8*gi +: 8] = reg_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_SYNC;
            cmd_q       <= 8'h00;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            chk_q       <= 8'h00;
            tmo_q       <= 20'd0;
            resp_q      <= '0;
            len_q       <= 2'd0;
            idx_q       <= 2'd0;
            seen_busy_q <= 1'b0;
            tx_byte_q   <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            chk_q       <= chk_d;
            tmo_q       <= tmo_d;
            resp_q      <= resp_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            seen_busy_q <= seen_busy_d;
            tx_byte_q   <= tx_byte_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        data_d      = data_q;
        chk_d       = chk_q;
        tmo_d       = 20'd0;
        resp_d      = resp_q;
        len_d       = len_q;
        idx_d       = idx_q;
        seen_busy_d = seen_busy_q;
        tx_byte_d   = tx_byte_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;

        unique case (state_q)
            S_SYNC: begin
                if (uart.rx_valid && (uart.rx_byte == SYNC_BYTE)) begin
                    state_d = S_CMD;
                    chk_d   = 8'h00;
                end
            end
            S_CMD, S_ADDR, S_DATA, S_CHK: begin
                tmo_d = tmo_q + 20'd1;
                if (uart.rx_err) begin
                    state_d = S_SYNC;
                    tmo_d   = 20'd0;
                end else if (uart.rx_valid) begin
                    tmo_d = 20'd0;
                    chk_d = chk_q ^ uart.rx_byte;
                    case (state_q)
                        S_CMD: begin
                            cmd_d   = uart.rx_byte;
                            state_d = S_ADDR;
                        end
                        S_ADDR: begin
                            addr_d  = uart.rx_byte;
                            state_d = (cmd_q == CMD_WR) ? S_DATA : S_CHK;
                        end
                        S_DATA: begin
                            data_d  = uart.rx_byte;
                            state_d = S_CHK;
                        end
                        default: state_d = S_EXEC;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_SYNC;
                    tmo_d   = 20'd0;
                end
            end
            S_EXEC: begin
                idx_d   = 2'd0;
                state_d = S_TX;
                if (!frame_ok) begin
                    resp_d = {8'h00, 8'h00, RESP_ERR};
                    len_d  = 2'd1;
                end else if (is_wr) begin
                    resp_d      = {8'h00, 8'h00, RESP_OK};
                    len_d       = 2'd1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = addr_idx;
                end else begin
                    resp_d = {RESP_OK ^ rd_data, rd_data, RESP_OK};
                    len_d  = 2'd3;
                end
                tx_byte_d = frame_ok ? RESP_OK : RESP_ERR;
            end
            S_TX: begin
                if (!uart.tx_busy) begin
                    state_d     = S_WAIT;
                    seen_busy_d = 1'b0;
                end
            end
            S_WAIT: begin
                // The UART raises tx_busy a cycle after the request; only its falling edge ends the byte.
                if (uart.tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    if ((idx_q + 2'd1) < len_q) begin
                        idx_d     = idx_q + 2'd1;
                        tx_byte_d = resp_q[idx_q + 2'd1];
                        state_d   = S_TX;
                    end else begin
                        state_d = S_SYNC;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    // tx_start is gated by tx_busy so a UART still finishing a byte after reset is never overrun.
    always_comb begin
        uart.tx_start = (state_q == S_TX) && !uart.tx_busy;
        uart.tx_byte  = tx_byte_q;
        busy          = (state_q != S_SYNC);
        wr_strobe     = wr_strobe_q;
        wr_addr       = wr_addr_q;
    end

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench: each frame pushes its expected response bytes, a UART model
// pops and compares every transmitted byte; register file checked against a model.
module tb_uart_reg_responder;
    localparam int NREGS   = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 300;
    localparam int TX_CYC  = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREGS*8-1:0]   reg_out;
    logic                 wr_strobe;
    logic [ADDR_W-1:0]    wr_addr;
    logic                 busy;

    uart_reg_responder_if u_if ();

    uart_reg_responder #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart     (u_if.slave),
        .reg_out  (reg_out),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               failures = 0;
    logic [7:0]       exp_q [$];
    logic [7:0]       regs_m [NREGS];
    int               wr_cnt = 0;
    int               tx_cnt = 0;
    int               busy_cnt = 0;
    bit               start_pend = 1'b0;
    logic             prev_start = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREGS*8-1:0] model_flat();
        logic [NREGS*8-1:0] f;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = regs_m[i];
        return f;
    endfunction

    // UART model: accepts tx_start, raises tx_busy after the edge, holds it TX_CYC cycles.
    initial begin
        u_if.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_strobe === 1'b1) wr_cnt++;
            if (u_if.tx_start === 1'b1) begin
                check_val("tx_while_busy", u_if.tx_busy, 0);
                check_val("tx_back2back", prev_start, 0);
                tx_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("tx_unexpected_byte", 1, 0);
                end else begin
                    check_val("tx_byte", u_if.tx_byte, exp_q.pop_front());
                end
                start_pend = 1'b1;
            end
            prev_start = u_if.tx_start;
            @(posedge clk);
            #1;
            if (start_pend) begin
                u_if.tx_busy = 1'b1;
                busy_cnt     = TX_CYC;
                start_pend   = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) u_if.tx_busy = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !busy && !u_if.tx_busy) return;
        end
        check_val("idle_timeout", 1, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        u_if.rx_valid = 1'b1;
        u_if.rx_byte  = b;
        @(negedge clk);
        u_if.rx_valid = 1'b0;
        u_if.rx_byte  = 8'h00;
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] addr,
                         input logic [7:0] data, input bit bad_chk);
        logic [7:0] chk;
        logic [7:0] first;
        bit         is_wr, is_rd, ok;
        int         wr0, nresp;
        is_wr = (cmd == 8'h01);
        is_rd = (cmd == 8'h02);
        chk   = cmd ^ addr ^ (is_wr ? data : 8'h00);
        if (bad_chk) chk = (chk == 8'h00) ? 8'hFF : 8'h00;
        ok = !bad_chk && (is_wr || is_rd) && (addr < NREGS);
        if (!ok) begin
            exp_q.push_back(8'hEE);
        end else if (is_wr) begin
            exp_q.push_back(8'h5A);
            regs_m[addr[ADDR_W-1:0]] = data;
        end else begin
            exp_q.push_back(8'h5A);
            exp_q.push_back(regs_m[addr[ADDR_W-1:0]]);
            exp_q.push_back(8'h5A ^ regs_m[addr[ADDR_W-1:0]]);
        end
        nresp = exp_q.size();
        first = exp_q[0];
        wr0   = wr_cnt;
        send_byte(8'hA5);
        send_byte(cmd);
        send_byte(addr);
        if (is_wr) send_byte(data);
        @(negedge clk);
        u_if.rx_valid = 1'b1;
        u_if.rx_byte  = chk;
        @(posedge clk);
        #1;
        check_val("exec_busy", busy, 1);
        check_val("exec_no_strobe", wr_strobe, 0);
        @(negedge clk);
        u_if.rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("tx_start_n2", u_if.tx_start, 1);
        check_val("tx_byte_n2", u_if.tx_byte, first);
        check_val("wr_strobe_n2", wr_strobe, ok && is_wr);
        if (ok && is_wr) check_val("wr_addr", wr_addr, addr[ADDR_W-1:0]);
        wait_idle();
        check_val("wr_count", wr_cnt - wr0, (ok && is_wr) ? 1 : 0);
        check_val("reg_file", reg_out, model_flat());
        $display("txn cmd=%02h addr=%02h data=%02h chk=%02h resp_bytes=%0d", cmd, addr, data, chk, nresp);
    endtask

    initial begin
        logic [7:0] a, d;
        int         t0;
        u_if.rx_valid = 1'b0;
        u_if.rx_byte  = 8'h00;
        u_if.rx_err   = 1'b0;
        for (int i = 0; i < NREGS; i++) regs_m[i] = 8'h00;

        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy", busy, 0);
        check_val("rst_tx_start", u_if.tx_start, 0);
        check_val("rst_tx_byte", u_if.tx_byte, 0);
        check_val("rst_wr_strobe", wr_strobe, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_regs", reg_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame(8'h01, 8'h03, 8'h7E, 1'b0);
        frame(8'h02, 8'h03, 8'h00, 1'b0);
        frame(8'h01, 8'h03, 8'h11, 1'b1);
        frame(8'h02, 8'h10, 8'h00, 1'b0);
        frame(8'h07, 8'h00, 8'h00, 1'b0);
        frame(8'h01, 8'h0F, 8'hC3, 1'b0);
        frame(8'h02, 8'h0F, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, NREGS - 1));
            if (a == 8'h03) a = 8'h05;
            d = 8'($urandom_range(0, 255));
            frame(8'h01, a, d, 1'b0);
            frame(8'h02, a, 8'h00, 1'b0);
        end

        // Timeout: CMD accepted at edge t, abort lands exactly TIMEOUT edges later.
        send_byte(8'hA5);
        @(negedge clk);
        u_if.rx_valid = 1'b1;
        u_if.rx_byte  = 8'h01;
        @(posedge clk);
        #1;
        u_if.rx_valid = 1'b0;
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check_val("tmo_before_expiry", busy, 1);
        @(posedge clk);
        #1;
        check_val("tmo_expired", busy, 0);
        frame(8'h02, 8'h03, 8'h00, 1'b0);

        send_byte(8'hA5);
        send_byte(8'h02);
        check_val("mid_frame_busy", busy, 1);
        @(negedge clk);
        u_if.rx_err = 1'b1;
        @(posedge clk);
        #1;
        check_val("rx_err_abort", busy, 0);
        @(negedge clk);
        u_if.rx_err = 1'b0;

        send_byte(8'hA5);
        @(negedge clk);
        u_if.rx_valid = 1'b1;
        u_if.rx_byte  = 8'h02;
        u_if.rx_err   = 1'b1;
        @(posedge clk);
        #1;
        check_val("rx_err_wins", busy, 0);
        @(negedge clk);
        u_if.rx_valid = 1'b0;
        u_if.rx_err   = 1'b0;
        wait_idle();

        send_byte(8'h00);
        send_byte(8'hFF);
        check_val("garbage_ignored", busy, 0);
        frame(8'h02, 8'h03, 8'h00, 1'b0);

        // Reset while the first byte of a read response is on the wire.
        exp_q.push_back(8'h5A);
        exp_q.push_back(regs_m[3]);
        exp_q.push_back(8'h5A ^ regs_m[3]);
        t0 = tx_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h01);
        for (int i = 0; i < 200 && tx_cnt == t0; i++) begin
            @(posedge clk);
            #2;
        end
        check_val("first_byte_seen", tx_cnt - t0, 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_tx_start", u_if.tx_start, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_regs", reg_out, 0);
        check_val("mid_rst_pending", exp_q.size(), 2);
        exp_q.delete();
        for (int i = 0; i < NREGS; i++) regs_m[i] = 8'h00;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        frame(8'h02, 8'h03, 8'h00, 1'b0);

        check_val("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

Byte-level command responder on the far side of the UART byte interface. It consumes received bytes, parses host command frames, and executes register writes and reads on an internal register file. It answers each frame by driving the UART transmit request/byte inputs. It sits between the UART and the control fabric that reads the register file.

## Interface
- NREGS, 16, number of 8-bit registers (2..256)
- ADDR_W, 4, register index width, equal to ceil(log2(NREGS))
- TIMEOUT, 500_000, maximum idle clk cycles between bytes of one frame (20-bit counter)
- clk  in  1  master clock
- rst_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle pulse: rx_byte holds a new byte (from UART received)
- rx_byte  in  8  received byte
- rx_err  in  1  one-cycle pulse: UART framing error (from UART recv_error)
- tx_busy  in  1  UART transmitter busy (from UART is_transmitting)
- tx_start  out  1  one-cycle transmit request (to UART transmit)
- tx_byte  out  8  byte to transmit; held stable from tx_start until tx_busy falls
- reg_out  out  NREGS*8  flat register file; register i at bits [8i+7:8i]
- wr_strobe  out  1  one-cycle pulse when a register is written
- wr_addr  out  ADDR_W  index written, valid with wr_strobe
- busy  out  1  high whenever state != S_SYNC

## Operation
- Host frame: SYNC 0xA5, CMD, ADDR, [DATA if CMD=0x01], CHK. CHK = XOR of every byte after SYNC.
- CMD 0x01 = write, 0x02 = read. Any other CMD is parsed as a read-length frame (no DATA byte) and NAKed.
- Responses:
  - write OK: 0x5A
  - read OK: 0x5A, DATA, CHK (0x5A ^ DATA)
  - any error: 0xEE
- Errors: CHK mismatch, unknown CMD, ADDR >= NREGS. On error, no register changes.
- States:
  - S_SYNC: wait for a byte equal to 0xA5; other bytes are discarded silently.
  - S_CMD, S_ADDR, S_DATA, S_CHK: each latches one byte on rx_valid and XORs it into the running checksum. The checksum is cleared on entry to S_CMD.
  - S_EXEC (1 cycle): validate, perform the write or read, and load the response buffer (1 or 3 bytes) and its length.
  - S_TX: send buffered bytes one at a time.
  - S_WAIT: after tx_start, wait for tx_busy=1, then for tx_busy=0. Then either send the next byte in S_TX or return to S_SYNC.
- Frame abort: rx_err in any of S_CMD..S_CHK, or the timeout expiring, returns to S_SYNC. No response is sent and no write occurs.
- Timeout counter: reloads on every accepted byte; counts only in S_CMD..S_CHK.
- In S_EXEC, S_TX and S_WAIT, rx_valid and rx_err are ignored and incoming bytes are dropped.
- rx_valid and rx_err in the same cycle: rx_err wins (abort).

## Timing
- Reset (async assert, sync release): state S_SYNC, all registers 0x00, tx_start 0, tx_byte 0x00, wr_strobe 0, wr_addr 0, busy 0, timeout counter cleared.
- CHK byte rx_valid at cycle N: S_EXEC at N+1. For a valid write, reg_out and wr_strobe/wr_addr update at N+2 (registered).
- First tx_start is asserted at N+2. tx_byte is valid in the same cycle and held until tx_busy falls.
- tx_start is never asserted while tx_busy=1, and never in two consecutive cycles.
- Next byte's tx_start comes 1 cycle after tx_busy is seen low in S_WAIT.
- The cycle after the last byte's tx_busy falls, state is S_SYNC and busy=0.
- Timeout: after TIMEOUT cycles without rx_valid in a mid-frame state, state is S_SYNC on the next cycle.
- A read of a register issued immediately after a write to it returns the new value.
- Reset mid-response: tx_start drops to 0 immediately. The UART may finish its current byte; the block ignores it.

## Test plan
- Write: A5 01 03 7E 7C -> reg 3 = 0x7E, wr_strobe pulses once with wr_addr=3, response 5A.
- Read back: A5 02 03 01 -> response 5A 7E 24. Each tx_start is issued only after the previous tx_busy falls.
- Bad checksum: A5 01 03 7E 00 -> response EE, reg 3 unchanged, no wr_strobe.
- Address and command range: A5 02 10 12 (NREGS=16) -> EE; A5 07 00 07 -> EE.
- Abort and resync:
  - A5 01 then a gap > TIMEOUT, then A5 02 03 01 -> single response 5A 7E 24 only.
  - rx_err after A5 02 -> no response.
  - Garbage bytes 00 FF before A5 -> ignored.
- Reset mid-response: assert rst_n low after the first 5A of a read -> tx_start 0, all registers 0x00, busy 0. After release, A5 02 03 01 -> 5A 00 5A.
